// File: rtl/multiplier_control.sv
// Sequencer for the signed shift-add multiplier datapath.
// Define MULT_SKIP_ZERO_EN to fold the shift into ADD when M = 0.
module multiplier_control #(
  parameter int N_BITS = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic run_i,
  input  logic clra_ldb_i,
  input  logic m_i,
  output logic clr_ld_o,
  output logic clr_xa_o,
  output logic add_en_o,
  output logic sub_en_o,
  output logic shift_en_o,
  output logic busy_o,
  output logic done_o
);

  localparam int KW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLRXA,
    S_ADD,
    S_SHIFT,
    S_HOLD
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            k_last;

  assign k_last = (k_q == K_LAST);

  // State and iteration counter registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic and per-cycle datapath strobes.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    clr_ld_o   = 1'b0;
    clr_xa_o   = 1'b0;
    add_en_o   = 1'b0;
    sub_en_o   = 1'b0;
    shift_en_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        clr_ld_o = clra_ldb_i;
        if (!clra_ldb_i && run_i) begin
          state_d = S_CLRXA;
        end
      end
      S_CLRXA: begin
        busy_o   = 1'b1;
        clr_xa_o = 1'b1;
        k_d      = '0;
        state_d  = S_ADD;
      end
      S_ADD: begin
        busy_o = 1'b1;
`ifdef MULT_SKIP_ZERO_EN
        if (!m_i) begin
          shift_en_o = 1'b1;
          if (k_last) begin
            state_d = S_HOLD;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = S_ADD;
          end
        end else begin
          add_en_o = !k_last;
          sub_en_o = k_last;
          state_d  = S_SHIFT;
        end
`else
        add_en_o = m_i && !k_last;
        sub_en_o = m_i && k_last;
        state_d  = S_SHIFT;
`endif
      end
      S_SHIFT: begin
        busy_o     = 1'b1;
        shift_en_o = 1'b1;
        if (k_last) begin
          state_d = S_HOLD;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = S_ADD;
        end
      end
      S_HOLD: begin
        done_o = 1'b1;
        if (!run_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
